// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 front end: fetch FSM states, width defaults
// and the bit positions of the decode fields.
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int F7B5_BIT = 30;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux: redirect target wins over
// the sequential +4 advance, otherwise the PC holds.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (advance) begin
            pc_next = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding imem request, registered
// instruction buffer to decode. Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc4,
    output logic [6:0]      op,
    output logic [2:0]      f3,
    output logic            f7b5,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misalign_err
);

    fetch_state_e    state;
    logic            kill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic            advance;
    logic            req_fire;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign_trap;
    assign target        = redirect_target;
    assign misalign_trap = redirect && (redirect_target[1:0] != 2'b00);
`else
    // Without the trap a misaligned target is silently word-aligned.
    assign target       = redirect_target & ~XLEN'(3);
    assign misalign_err = 1'b0;
`endif

    assign req_fire = imem_req_valid && imem_req_ready;
    assign advance  = (state == HOLD) && instr_valid && instr_ready;

    assign op   = instr[OP_MSB:OP_LSB];
    assign f3   = instr[F3_MSB:F3_LSB];
    assign f7b5 = instr[F7B5_BIT];

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect        (redirect),
        .redirect_target (target),
        .advance         (advance),
        .pc              (pc),
        .pc_next         (pc_next)
    );

    // Every entry into REQ issues pc_next, so a same-cycle redirect is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            kill           <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            instr_pc4      <= XLEN'(4);
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_err   <= 1'b0;
`endif
        end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (misalign_trap) begin
                misalign_err   <= 1'b1;
                state          <= HALT;
                kill           <= 1'b0;
                imem_req_valid <= 1'b0;
                instr_valid    <= 1'b0;
            end else
`endif
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                    imem_req_addr  <= pc_next;
                end
                REQ: begin
                    if (req_fire) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        kill           <= redirect;
                    end else begin
                        imem_req_addr  <= pc_next;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redirect) begin
                            kill           <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= pc_next;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_pc    <= pc;
                            instr_pc4   <= pc + XLEN'(4);
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (advance || redirect) begin
                        instr_valid    <= 1'b0;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= pc_next;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end for the 32-bit RISC-V core. Owns the PC and issues one-at-a-time requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents the fetched word, its PC, and the decode fields (op, f3, f7b5) to the control/decode stage through a valid/ready handshake.
- Consumes the taken-branch/jump redirect (pcSrc plus target) produced downstream.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response pulse, one per accepted request
- imem_rsp_data  in  XLEN  instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode consumes instruction
- instr  out  XLEN  instruction word
- instr_pc  out  XLEN  PC of instr
- instr_pc4  out  XLEN  instr_pc + 4
- op  out  7  instr[6:0]
- f3  out  3  instr[14:12]
- f7b5  out  1  instr[30]
- redirect  in  1  pcSrc from controller
- redirect_target  in  XLEN  branch/jump target
- misalign_err  out  1  see Optional Feature (tied 0 when disabled)

Behaviour:
- Reset is asynchronous, active-low, and applies regardless of state. It sets:
  - state = IDLE, pc = RESET_PC, kill = 0;
  - imem_req_valid = 0, instr_valid = 0;
  - instr, instr_pc, and misalign_err = 0; instr_pc4 = 4.
- All outputs are registered, except op, f3 and f7b5, which are wired slices of instr.
- IDLE: on the first clk edge after reset release, go to REQ and drive imem_req_valid = 1 with imem_req_addr = pc.
- REQ:
  - imem_req_valid stays high and imem_req_addr stays stable until imem_req_valid && imem_req_ready; then go to WAIT.
  - Exception to address stability: a redirect while the request is not yet accepted replaces imem_req_addr with redirect_target on the next cycle.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid with kill = 0: latch instr = imem_rsp_data and instr_pc = pc, set instr_valid = 1, go to HOLD.
  - On imem_rsp_valid with kill = 1: discard the word, clear kill, go to REQ with the current pc.
- HOLD:
  - instr, instr_pc and instr_valid are held until instr_valid && instr_ready.
  - On that handshake: pc <= pc + 4 (modulo 2^XLEN, wraps from 32'hFFFF_FFFC to 0), instr_valid <= 0, go to REQ.
  - Best-case throughput is one instruction every 3 cycles with a zero-wait imem.
- Redirect has the highest priority and takes effect in the same cycle:
  - pc <= redirect_target in every state.
  - REQ, not accepted: re-issue with the new address.
  - REQ, accepted the same cycle: go to WAIT with kill = 1.
  - WAIT: kill <= 1. If imem_rsp_valid arrives in the same cycle, discard it directly and go to REQ.
  - HOLD: instr_valid <= 0, go to REQ. A simultaneous instr_ready handshake still completes, but redirect_target wins over pc + 4.
  - IDLE: pc <= target; REQ follows as normal.
- imem_rsp_valid outside WAIT is a protocol violation. It is ignored, and the bench asserts that it never occurs.
- Only one request is outstanding at any time.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Enabled:
  - A redirect with redirect_target[1:0] != 0 sets misalign_err = 1 (sticky until reset).
  - Any in-flight response is discarded, instr_valid = 0, and the FSM enters HALT: no further requests, and instr_valid stays 0.
- Disabled:
  - misalign_err is tied to 0, and the HALT state is not built.
  - The target's low two bits are forced to 0 before loading pc.

Decomposition:
- Shared package riscv_pkg holds:
  - the fetch state enum (IDLE, REQ, WAIT, HOLD, HALT);
  - XLEN_DEF, RESET_PC_DEF;
  - decode field index constants: OP_LSB/MSB, F3_LSB/MSB, F7B5_BIT.
- One sub-module is natural: pc_reg, which holds the PC register plus the next-PC mux (reset / redirect / +4). The FSM and handshake logic stay in ifetch_unit.

Test Plan:
- Reset, then imem always ready with a 1-cycle response returning 32'h00000013 at addr 0 and 4. Required: first imem_req_valid the cycle after IDLE; instr_pc values 0 then 4; op = 7'h13, f3 = 0.
- instr_ready held low 5 cycles in HOLD with word 32'h40B50533. Required: instr, instr_pc and instr_valid stable throughout; f7b5 = 1; no new request until the handshake.
- imem_req_ready low for 3 cycles. Required: imem_req_addr stable; redirect to 32'h100 in the 2nd cycle gives addr = 32'h100 on the next cycle.
- Redirect to 32'h200 while in WAIT, response 32'hDEADBEEF two cycles later. Required: the word is never presented; the next request goes to addr 32'h200.
- Redirect to 32'h80 in the same cycle as an instr handshake at pc 32'h10. Required: next request addr is 32'h80, not 32'h14.
- With IFETCH_MISALIGN_TRAP_EN, redirect to 32'h102. Required: misalign_err = 1 and imem_req_valid stays 0 thereafter. Without the macro, the next addr is 32'h100.
